// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 constants, M-extension funct3 codes and muldiv state encoding
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } muldiv_state_t;

    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - start/busy/done bundle between controller/register file and muldiv_unit
interface muldiv_unit_if;
    import riscv_pkg::*;

    logic             start;
    logic [2:0]       op;
    logic [XLEN-1:0]  rs1Val;
    logic [XLEN-1:0]  rs2Val;
    logic [REG_W-1:0] rdIn;
    logic             busy;
    logic             done;
    logic [XLEN-1:0]  result;
    logic [REG_W-1:0] rdOut;

    modport master (
        output start, op, rs1Val, rs2Val, rdIn,
        input  busy, done, result, rdOut
    );

    modport slave (
        input  start, op, rs1Val, rs2Val, rdIn,
        output busy, done, result, rdOut
    );

endinterface

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - sign correction, word select and divide special cases for muldiv_unit
module muldiv_sign_fix
    import riscv_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [2*XLEN-1:0] product,
    input  logic [XLEN-1:0]   quotient,
    input  logic [XLEN-1:0]   remainder,
    input  logic              sign_a,
    input  logic              sign_b,
    input  logic              div_zero,
    input  logic              div_ovf,
    output logic [XLEN-1:0]   result
);

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;

    always_comb begin
        prod_s = (sign_a ^ sign_b) ? -product : product;
        quo_s  = (sign_a ^ sign_b) ? -quotient : quotient;
        // A zero divisor leaves the full dividend magnitude in the remainder, so re-signing restores rs1.
        rem_s  = sign_a ? -remainder : remainder;
        result = '0;
        case (op)
            OP_MUL:                       result = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = div_zero ? '1
                                                 : div_ovf ? {1'b1, {(XLEN-1){1'b0}}}
                                                 : quo_s;
            OP_REM, OP_REMU:              result = div_ovf ? '0 : rem_s;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, 32 shift-add / restoring steps per op
module muldiv_unit
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);

    muldiv_state_t     state;
    muldiv_state_t     state_next;
    logic [4:0]        cnt;
    logic [2:0]        op_q;
    logic [REG_W-1:0]  rd_q;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              sign_a;
    logic              sign_b;
    logic              div_zero;
    logic              div_ovf;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   result_q;
    logic [REG_W-1:0]  rd_out_q;

    logic              in_sign_a;
    logic              in_sign_b;
    logic [XLEN-1:0]   in_a_mag;
    logic [XLEN-1:0]   in_b_mag;
    logic              in_ovf;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_part;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   fix_result;

    always_comb begin
        in_sign_a = bus.rs1Val[XLEN-1] & op_signed_a(bus.op);
        in_sign_b = bus.rs2Val[XLEN-1] & op_signed_b(bus.op);
        in_a_mag  = in_sign_a ? -bus.rs1Val : bus.rs1Val;
        in_b_mag  = in_sign_b ? -bus.rs2Val : bus.rs2Val;
        in_ovf    = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                    (bus.rs1Val == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2Val == '1);
    end

    // acc = {partial product high, multiplier} for MUL*, {partial remainder, dividend/quotient} for DIV*/REM*.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? a_mag : {XLEN{1'b0}})};
        div_part = acc[2*XLEN-1:XLEN-1];
        div_ge   = div_part >= {1'b0, b_mag};
        div_diff = div_part[XLEN-1:0] - b_mag;
    end

    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (bus.start) state_next = MD_CALC;
            MD_CALC: if (cnt == 5'd31) state_next = MD_FIX;
            MD_FIX:  state_next = MD_DONE;
            MD_DONE: state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            acc      <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (bus.start) begin
                        op_q     <= bus.op;
                        rd_q     <= bus.rdIn;
                        a_mag    <= in_a_mag;
                        b_mag    <= in_b_mag;
                        sign_a   <= in_sign_a;
                        sign_b   <= in_sign_b;
                        div_zero <= (bus.rs2Val == '0);
                        div_ovf  <= in_ovf;
                        cnt      <= '0;
                        acc      <= {{XLEN{1'b0}}, (op_is_div(bus.op) ? in_a_mag : in_b_mag)};
                    end
                end
                MD_CALC: begin
                    cnt <= cnt + 5'd1;
                    if (op_is_div(op_q))
                        acc <= div_ge ? {div_diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
                    else
                        acc <= {mul_sum, acc[XLEN-1:1]};
                end
                MD_FIX: begin
                    result_q <= fix_result;
                    rd_out_q <= rd_q;
                end
                default: ;
            endcase
        end
    end

    muldiv_sign_fix u_sign_fix (
        .op        (op_q),
        .product   (acc),
        .quotient  (acc[XLEN-1:0]),
        .remainder (acc[2*XLEN-1:XLEN]),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .div_zero  (div_zero),
        .div_ovf   (div_ovf),
        .result    (fix_result)
    );

    assign bus.busy   = (state != MD_IDLE);
    assign bus.done   = (state == MD_DONE);
    assign bus.result = result_q;
    assign bus.rdOut  = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - vector table, corner sequences and random ops against an arithmetic model
module tb_muldiv_unit;
    import riscv_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    muldiv_unit_if bus();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa = a;
        int          sb = b;
        longint      ps;
        logic [63:0] pu;
        bit          ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_MUL:    begin pu = {32'h0, a} * {32'h0, b}; return pu[31:0]; end
            OP_MULH:   begin ps = longint'(sa) * longint'(sb); pu = ps; return pu[63:32]; end
            OP_MULHSU: begin ps = longint'(sa) * longint'({32'h0, b}); pu = ps; return pu[63:32]; end
            OP_MULHU:  begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
            OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Called just after a negedge; returns at the negedge following the done pulse.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int poke,
                          output logic [31:0] res, output logic [4:0] rdo, output int lat, output int dcyc);
        bit seen = 0;
        bus.start = 1'b1; bus.op = op; bus.rs1Val = a; bus.rs2Val = b; bus.rdIn = rd;
        lat = 0;
        dcyc = 0;
        while (!seen && lat < 60) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                bus.start = 1'b0; bus.rs1Val = $urandom; bus.rs2Val = $urandom; bus.rdIn = 5'($urandom);
            end
            if (lat == poke) begin
                bus.start = 1'b1; bus.op = OP_DIVU; bus.rs1Val = $urandom; bus.rs2Val = 32'd3; bus.rdIn = ~rd;
            end else if (lat == poke + 1) begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                seen = 1;
                dcyc = cyc;
            end
        end
        res = bus.result;
        rdo = bus.rdOut;
        check("done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("busy_clear", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        vec_t        vecs[16];
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        int          d1;
        int          d2;
        int          dones;

        vecs[0]  = '{OP_MUL,    32'd7,          32'd252,        32'h0000_06E4};
        vecs[1]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000};
        vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
        vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF};
        vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[6]  = '{OP_DIVU,   32'd252,        32'd7,          32'd36};
        vecs[7]  = '{OP_REMU,   32'd252,        32'd7,          32'd0};
        vecs[8]  = '{OP_DIV,    32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[9]  = '{OP_REMU,   32'd5,          32'd0,          32'd5};
        vecs[10] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[11] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[12] = '{OP_REM,    32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
        vecs[13] = '{OP_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[14] = '{OP_MULH,   32'hFFFF_FFF9,  32'd3,          32'hFFFF_FFFF};
        vecs[15] = '{OP_MUL,    32'hFFFF_FFF9,  32'd3,          32'hFFFF_FFEB};

        bus.start = 1'b0; bus.op = '0; bus.rs1Val = '0; bus.rs2Val = '0; bus.rdIn = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_rdout", 32'(bus.rdOut), 32'd0);

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 5), -1, res, rdo, lat, d1);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd34);
            check($sformatf("vec%0d_rdout", i), 32'(rdo), 32'(i + 5));
        end

        // Second start lands in cycle 10 of a running MUL and must be dropped.
        run_op(OP_MUL, 32'h0001_2345, 32'h0000_5678, 5'd7, 10, res, rdo, lat, d1);
        check("ignore_result", res, ref_result(OP_MUL, 32'h0001_2345, 32'h0000_5678));
        check("ignore_rdout", 32'(rdo), 32'd7);
        check("ignore_latency", 32'(lat), 32'd34);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op = 3'($urandom_range(0, 7));
            logic [31:0] a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            logic [31:0] b;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op(op, a, b, 5'(i), -1, res, rdo, lat, d1);
            check($sformatf("rand%0d_op%0d_%08h_%08h", i, op, a, b), res, ref_result(op, a, b));
        end

        run_op(OP_DIVU, 32'd1000, 32'd7, 5'd3, -1, res, rdo, lat, d1);
        check("b2b_divu_result", res, 32'd142);
        run_op(OP_MUL, 32'h0001_0001, 32'h30, 5'd4, -1, res, rdo, lat, d2);
        check("b2b_mul_result", res, 32'h0030_0030);
        check("b2b_mul_rdout", 32'(rdo), 32'd4);
        check("b2b_done_spacing", 32'(d2 - d1), 32'd35);

        bus.start = 1'b1; bus.op = OP_DIV; bus.rs1Val = 32'd100; bus.rs2Val = 32'd3; bus.rdIn = 5'd11;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_rdout", 32'(bus.rdOut), 32'd0);
        reset = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("abort_start_ignored", 32'(bus.busy), 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit. Sits directly downstream of the register file: takes the two read-port operands (rs1, rs2) plus destination index, computes the M-extension result over a fixed number of cycles, and returns the result and destination index to the register-file write port. Start/busy/done handshake lets the controller stall the datapath while an operation is in flight.

## Interface

- No parameters; data width fixed at 32, register index fixed at 5.
- Reset: `reset`, synchronous, active-high. Clock: `clk`.
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high; aborts any operation
- start  in  1  request; accepted only when busy=0
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1Val  in  32  operand A / dividend (register-file outRS1)
- rs2Val  in  32  operand B / divisor (register-file outRS2)
- rdIn  in  5  destination register index
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; result/rdOut valid; drives register-file rWrite
- result  out  32  final result; held stable until the next done
- rdOut  out  5  destination index captured at accept (register-file rsWrite)

## Operation

- States: IDLE, CALC, FIX, DONE.
- IDLE: on start=1, latch op, rdIn, operand magnitudes and sign flags; clear accumulator; iteration counter=0; go CALC. Operands may change after the accept edge.
- Signedness: MULH/DIV/REM both operands signed; MULHSU rs1 signed, rs2 unsigned; MUL/MULHU/DIVU/REMU unsigned magnitudes (MUL low word is sign-agnostic).
- CALC multiply: radix-2 shift-add on magnitudes into 64-bit product, one bit per cycle.
- CALC divide: restoring division on magnitudes, 32-bit quotient and 33-bit partial remainder, one bit per cycle.
- CALC lasts exactly 32 cycles (counter 0..31), then FIX.
- FIX: apply sign correction, select word, apply special cases, register into result.
  - Product negated if operand signs differ (signed variants only); MUL returns low word, MULH* high word.
  - Quotient negative iff sign(A) xor sign(B); remainder takes sign of dividend.
  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend unchanged.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- DONE: done=1 for one cycle; go IDLE.
- start while busy=1 (CALC/FIX/DONE) ignored, no effect.

## Timing

- Reset values: busy=0, done=0, result=0, rdOut=0, state=IDLE.
- Fixed latency for every op including special cases: start accepted at edge T -> done high in cycle following edge T+34; busy high from edge T+1 to edge T+35.
- Back-to-back: start asserted in the cycle busy=0 again (after DONE) is accepted; throughput 1 op per 35 cycles.
- result and rdOut update at the FIX->DONE edge only; stable from done until the next done.
- reset mid-operation: at the reset edge, state=IDLE, outputs to reset values, no done for the aborted op; start concurrent with reset ignored.
- No combinational path from inputs to outputs.

## Structure

- Shared package riscv_pkg: funct3 op localparams (OP_MUL..OP_REMU), muldiv state encoding, XLEN=32 constant.
- One natural sub-module: muldiv_sign_fix (combinational) — takes raw product/quotient/remainder, sign flags, op, zero/overflow flags; returns final 32-bit result. FSM, counter and datapath registers stay in muldiv_unit.

## Test plan

- MUL rs1=7, rs2=252, rdIn=5 -> done exactly 34 cycles after accept, result=0x000006E4, rdOut=5, one-cycle done.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 252/7 -> 36; REMU 252/7 -> 0.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; all at 34-cycle latency.
- start pulsed at cycle 10 of a running MUL with different operands -> ignored, original result delivered; reset at cycle 10 of another op -> busy=0, result=0 next edge, no done.
- Back-to-back DIVU then MUL, second start in first cycle busy=0 -> both done pulses 35 cycles apart, correct results.
